// File: rtl/muldiv_hilo.sv
// ---------------------------------------------------------------------------
// muldiv_hilo
//   HI/LO register pair and the multiply/divide engine that feeds it (EX stage).
//   - MTHI/MTLO and MULT/MULTU complete on the issuing edge.
//   - DIV/DIVU use a radix-2 restoring divider, one quotient bit per cycle.
//   - busy stalls the pipeline while a divide is in flight.
//   - flush squashes an in-flight divide without touching HI/LO.
//
// Optional feature: define HILO_MACC_EN to enable MADD (op 110) and MSUB (op 111),
//   which accumulate a signed product into {HI,LO}. Without the macro those
//   opcodes are ignored (no write, no done).
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      issue op; sampled only when busy==0
//   op        in   3      000 MTHI, 001 MTLO, 010 MULT, 011 MULTU,
//                         100 DIV, 101 DIVU, 110 MADD, 111 MSUB
//   rs_data   in   WIDTH  operand A / dividend / MTHI-MTLO source
//   rt_data   in   WIDTH  operand B / divisor
//   flush     in   1      synchronous abort of an in-flight divide
//   busy      out  1      divide in progress; new starts ignored
//   done      out  1      one-cycle pulse when the op's result becomes visible
//   div_zero  out  1      valid with done; divide by zero, HI/LO untouched
//   hi_o      out  WIDTH  HI register
//   lo_o      out  WIDTH  LO register
// ---------------------------------------------------------------------------
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_DIV_RUN = 2'b01;
  localparam logic [1:0] S_DIV_FIN = 2'b10;

  localparam logic [2:0] OP_MTHI  = 3'b000;
  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
`ifdef HILO_MACC_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  // Two's-complement negation, used for operand magnitudes and result signs.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE_W;
  endfunction

  // Architectural and divider state.
  logic [1:0]       state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] quo_q,      quo_d;    // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] rem_q,      rem_d;    // partial remainder, always < divisor
  logic [WIDTH-1:0] dsor_q,     dsor_d;   // divisor magnitude
  logic             q_neg_q,    q_neg_d;
  logic             r_neg_q,    r_neg_d;
  logic             dz_q,       dz_d;     // current divide has a zero divisor

  // Combinational helpers.
  logic                 mul_signed_s;
  logic                 div_signed_s;
  logic [2*WIDTH-1:0]   mul_a_s;
  logic [2*WIDTH-1:0]   mul_b_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH:0]       rem_shift_s;
  logic [WIDTH:0]       diff_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
`ifdef HILO_MACC_EN
  logic [2*WIDTH-1:0]   acc_s;
`endif

  // Multiplier: operands are extended to 2*WIDTH so the low half of an
  // unsigned multiply gives the exact signed or unsigned product.
  always_comb begin
    mul_signed_s = (op != OP_MULTU);
    if (mul_signed_s) begin
      mul_a_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data};
      mul_b_s = {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    end else begin
      mul_a_s = {{WIDTH{1'b0}}, rs_data};
      mul_b_s = {{WIDTH{1'b0}}, rt_data};
    end
    prod_s = mul_a_s * mul_b_s;
  end

`ifdef HILO_MACC_EN
  // Accumulator adder for MADD/MSUB; op[0] selects subtract.
  always_comb begin
    if (op[0]) begin
      acc_s = {hi_q, lo_q} - prod_s;
    end else begin
      acc_s = {hi_q, lo_q} + prod_s;
    end
  end
`endif

  // Divider step datapath and operand sign detection.
  always_comb begin
    div_signed_s = (op == OP_DIV);
    a_neg_s      = div_signed_s & rs_data[WIDTH-1];
    b_neg_s      = div_signed_s & rt_data[WIDTH-1];
    rem_shift_s  = {rem_q, quo_q[WIDTH-1]};
    diff_s       = rem_shift_s - {1'b0, dsor_q};
  end

  // Next-state logic for the FSM, HI/LO and the status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dsor_d     = dsor_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // flush takes priority over a same-cycle start.
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          case (op)
            OP_MTHI: begin
              hi_d   = rs_data;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs_data;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              {hi_d, lo_d} = prod_s;
              done_d       = 1'b1;
            end
`ifdef HILO_MACC_EN
            OP_MADD, OP_MSUB: begin
              {hi_d, lo_d} = acc_s;
              done_d       = 1'b1;
            end
`endif
            OP_DIV, OP_DIVU: begin
              q_neg_d = a_neg_s ^ b_neg_s;
              r_neg_d = a_neg_s;
              quo_d   = a_neg_s ? negate(rs_data) : rs_data;
              dsor_d  = b_neg_s ? negate(rt_data) : rt_data;
              rem_d   = ZERO_W;
              cnt_d   = {CW{1'b0}};
              if (rt_data == ZERO_W) begin
                dz_d    = 1'b1;
                state_d = S_DIV_FIN;
              end else begin
                dz_d    = 1'b0;
                state_d = S_DIV_RUN;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DIV_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // Restoring step: keep the subtraction only if it did not borrow.
          if (!diff_s[WIDTH]) begin
            rem_d = diff_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_d = S_DIV_FIN;
          end else begin
            state_d = S_DIV_RUN;
          end
        end
      end

      S_DIV_FIN: begin
        state_d = S_IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else if (dz_q) begin
          done_d     = 1'b1;
          div_zero_d = 1'b1;
        end else begin
          // MIN / -1 wraps naturally: magnitude 2^(WIDTH-1) negates to itself.
          lo_d   = q_neg_q ? negate(quo_q) : quo_q;
          hi_d   = r_neg_q ? negate(rem_q) : rem_q;
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      hi_q       <= ZERO_W;
      lo_q       <= ZERO_W;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      quo_q      <= ZERO_W;
      rem_q      <= ZERO_W;
      dsor_q     <= ZERO_W;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dsor_q     <= dsor_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_q       <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// ---------------------------------------------------------------------------
// tb_muldiv_hilo
//   Directed-vector bench for muldiv_hilo (WIDTH=32). Inputs are driven and
//   outputs sampled on the falling edge; the rising edge is the active edge.
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_muldiv_hilo;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one rising edge, then scramble the operands so the
  // DUT must rely on its latched copies. Returns at the falling edge after the
  // start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start   = 1'b0;
    rs_data = 32'hDEAD_BEEF;
    rt_data = 32'h0BAD_F00D;
  endtask

  // Count edges (start edge = 1) until done is seen, bounded. busy must stay
  // high on every sample before done.
  task automatic wait_done(output int edges, output logic busy_ok);
    edges   = 1;
    busy_ok = 1'b1;
    while (!done && edges < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic div_vec(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int   edges;
    logic busy_ok;
    issue(o, a, b);
    wait_done(edges, busy_ok);
    check({tag, "_lat"},  64'(edges), 64'd34);
    check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, "_lo"},   {32'd0, lo_o}, {32'd0, exp_lo});
    check({tag, "_hi"},   {32'd0, hi_o}, {32'd0, exp_hi});
    check({tag, "_dz"},   {63'd0, div_zero}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int   edges;
    logic busy_ok;
    int   done_seen;

    rst     = 1'b1;
    start   = 1'b0;
    op      = 3'b000;
    rs_data = 32'd0;
    rt_data = 32'd0;
    flush   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_hi",   {32'd0, hi_o}, 64'd0);
    check("rst_lo",   {32'd0, lo_o}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz",   {63'd0, div_zero}, 64'd0);
    rst = 1'b0;

    // 1. MULT / MULTU
    issue(3'b010, 32'hFFFF_FFFE, 32'd3);
    check("mult_done", {63'd0, done}, 64'd1);
    check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    check("mult_done_pulse", {63'd0, done}, 64'd0);
    issue(3'b011, 32'hFFFF_FFFE, 32'd3);
    check("multu_done", {63'd0, done}, 64'd1);
    check("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

    // 2. Signed and unsigned divides, including sign rules and MIN/-1
    div_vec("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div_vec("divu_7_2",   3'b101, 32'd7,         32'd2,         32'd3,         32'd1);
    div_vec("div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    div_vec("div_min_m1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    div_vec("divu_big",   3'b101, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);

    // 3. MTHI/MTLO then divide by zero
    issue(3'b000, 32'hAAAA_AAAA, 32'd0);
    check("mthi_done", {63'd0, done}, 64'd1);
    check("mthi_hilo", {hi_o, lo_o}, {32'hAAAA_AAAA, 32'h0000_FFFF});
    issue(3'b001, 32'h5555_5555, 32'd0);
    check("mtlo_hilo", {hi_o, lo_o}, 64'hAAAA_AAAA_5555_5555);
    issue(3'b100, 32'd5, 32'd0);
    wait_done(edges, busy_ok);
    check("dz_lat",  64'(edges), 64'd2);
    check("dz_flag", {63'd0, div_zero}, 64'd1);
    check("dz_hilo", {hi_o, lo_o}, 64'hAAAA_AAAA_5555_5555);
    @(negedge clk);
    check("dz_pulse", {62'd0, done, div_zero}, 64'd0);

    // 4. start while busy is ignored; flush aborts with no done
    issue(3'b100, 32'd100, 32'd3);          // now in divide cycle 1
    @(negedge clk);                         // cycle 2
    start = 1'b1; op = 3'b000; rs_data = 32'h1234_5678;
    @(negedge clk);                         // cycle 3 edge has passed
    start = 1'b0;
    check("busy_start_hi", {32'd0, hi_o}, 64'h0000_0000_AAAA_AAAA);
    check("busy_start_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);                         // cycle 4
    flush = 1'b1;
    @(negedge clk);                         // cycle 5 edge has passed
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hilo", {hi_o, lo_o}, 64'hAAAA_AAAA_5555_5555);

    // flush beats a same-cycle start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b001; rs_data = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_done", {63'd0, done}, 64'd0);
    check("flush_start_hilo", {hi_o, lo_o}, 64'hAAAA_AAAA_5555_5555);

    // 5. Async reset mid-divide, then a fresh divide
    issue(3'b100, 32'd100, 32'd3);
    for (int i = 0; i < 9; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hilo", {hi_o, lo_o}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    #1 rst = 1'b0;
    div_vec("divu_9_4", 3'b101, 32'd9, 32'd4, 32'd2, 32'd1);

    // 6. MADD / MSUB
    issue(3'b000, 32'd0, 32'd0);
    issue(3'b001, 32'hFFFF_FFFF, 32'd0);
`ifdef HILO_MACC_EN
    issue(3'b110, 32'd1, 32'd1);
    check("madd_done", {63'd0, done}, 64'd1);
    check("madd_hilo", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
    issue(3'b111, 32'd2, 32'd1);
    check("msub_done", {63'd0, done}, 64'd1);
    check("msub_hilo", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFE);
`else
    issue(3'b110, 32'd1, 32'd1);
    check("madd_off_done", {63'd0, done}, 64'd0);
    check("madd_off_hilo", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);
    issue(3'b111, 32'd2, 32'd1);
    check("msub_off_done", {63'd0, done}, 64'd0);
    check("msub_off_hilo", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
